// File: rtl/musb_bus_pkg.sv
// Shared bus definitions: FSM state encoding, bus widths, payload struct and clog2.
package musb_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] wr;
    } bus_req_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request searching upward from last_grant+1, wrapping.
module rr_priority_picker #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    int unsigned w_cand;

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_cand = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = (32'(last_grant) + k) % N;
            if (!valid && req[IDX_W'(w_cand)]) begin
                valid = 1'b1;
                index = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with IDLE/BUSY FSM between NMASTERS masters and one slave port.
// Optional macro BUS_TIMEOUT_EN adds a BUSY watchdog that errors the granted master.
module bus_arbiter_rr
    import musb_bus_pkg::*;
#(
    parameter int unsigned NMASTERS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W*NMASTERS-1:0]   master_address,
    input  logic [DATA_W*NMASTERS-1:0]   master_data_i,
    input  logic [STRB_W*NMASTERS-1:0]   master_wr,
    input  logic [NMASTERS-1:0]          master_enable,
    output logic [DATA_W-1:0]            master_data_o,
    output logic [NMASTERS-1:0]          master_ready,
    output logic [NMASTERS-1:0]          master_error,
    input  logic [DATA_W-1:0]            slave_data_i,
    input  logic                         slave_ready,
    input  logic                         slave_error,
    output logic [ADDR_W-1:0]            slave_address,
    output logic [DATA_W-1:0]            slave_data_o,
    output logic [STRB_W-1:0]            slave_wr,
    output logic                         slave_enable
);

    localparam int unsigned IDX_W = clog2(NMASTERS);

    bus_state_e       r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_timeout;
    logic             w_done;
    bus_req_t         w_sel;

    rr_priority_picker #(
        .N     (NMASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (master_enable),
        .last_grant (r_last_grant),
        .valid      (w_pick_valid),
        .index      (w_pick_idx)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // Counts BUSY cycles; held at zero in IDLE so every BUSY entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == ST_IDLE) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // A slave reply in the deadline cycle takes precedence over the watchdog.
    assign w_timeout = (r_state == ST_BUSY) && (r_count == CNT_W'(TIMEOUT_CYCLES))
                       && !slave_ready && !slave_error;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign w_timeout            = 1'b0;
`endif

    assign w_sel = {master_address[32'(r_grant)*ADDR_W +: ADDR_W],
                    master_data_i[32'(r_grant)*DATA_W +: DATA_W],
                    master_wr[32'(r_grant)*STRB_W +: STRB_W]};

    // Abort (requester drops enable) ends the transfer just like a reply.
    assign w_done = slave_ready | slave_error | !master_enable[r_grant] | w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NMASTERS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign master_data_o = slave_data_i;

    // Slave side follows the granted master only while BUSY; everything is quiet in IDLE.
    always_comb begin
        slave_enable  = 1'b0;
        slave_address = '0;
        slave_data_o  = '0;
        slave_wr      = '0;
        master_ready  = '0;
        master_error  = '0;
        if (r_state == ST_BUSY) begin
            slave_enable           = master_enable[r_grant] & ~w_timeout;
            slave_address          = w_sel.addr;
            slave_data_o           = w_sel.data;
            slave_wr               = w_sel.wr;
            master_ready[r_grant]  = slave_ready;
            master_error[r_grant]  = slave_error | w_timeout;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr; with BUS_TIMEOUT_EN it checks the watchdog, otherwise a long stall.
module tb_bus_arbiter_rr;
    import musb_bus_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 4;

    logic                     clk;
    logic                     rst;
    logic [ADDR_W*N-1:0]      master_address;
    logic [DATA_W*N-1:0]      master_data_i;
    logic [STRB_W*N-1:0]      master_wr;
    logic [N-1:0]             master_enable;
    logic [DATA_W-1:0]        master_data_o;
    logic [N-1:0]             master_ready;
    logic [N-1:0]             master_error;
    logic [DATA_W-1:0]        slave_data_i;
    logic                     slave_ready;
    logic                     slave_error;
    logic [ADDR_W-1:0]        slave_address;
    logic [DATA_W-1:0]        slave_data_o;
    logic [STRB_W-1:0]        slave_wr;
    logic                     slave_enable;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter_rr #(
        .NMASTERS       (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .master_address (master_address),
        .master_data_i  (master_data_i),
        .master_wr      (master_wr),
        .master_enable  (master_enable),
        .master_data_o  (master_data_o),
        .master_ready   (master_ready),
        .master_error   (master_error),
        .slave_data_i   (slave_data_i),
        .slave_ready    (slave_ready),
        .slave_error    (slave_error),
        .slave_address  (slave_address),
        .slave_data_o   (slave_data_o),
        .slave_wr       (slave_wr),
        .slave_enable   (slave_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int m);
        return 32'h1000 * (m + 1);
    endfunction

    initial begin
        rst           = 1'b1;
        master_enable = '0;
        slave_ready   = 1'b0;
        slave_error   = 1'b0;
        slave_data_i  = '0;
        for (int m = 0; m < N; m++) begin
            master_address[m*32 +: 32] = addr_of(m);
            master_data_i[m*32 +: 32]  = 32'hA000_0000 + m;
            master_wr[m*4 +: 4]        = 4'(m + 1);
        end
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_slave_enable", slave_enable, 0);
        check("rst_ready", master_ready, 0);
        check("rst_error", master_error, 0);

        // Single master, reply on third BUSY cycle.
        master_address[0 +: 32] = 32'h100;
        master_enable = 3'b001;
        settle();
        check("single_idle_en", slave_enable, 0);
        tick();
        check("single_en_lat1", slave_enable, 1);
        check("single_addr", slave_address, 32'h100);
        check("single_data", slave_data_o, 32'hA000_0000);
        check("single_wr", slave_wr, 4'h1);
        tick();
        check("single_busy2_ready", master_ready, 0);
        tick();
        slave_ready = 1'b1;
        settle();
        check("single_ready", master_ready, 3'b001);
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b000;
        settle();
        check("single_after_ready", master_ready, 0);
        check("single_after_en", slave_enable, 0);
        master_address[0 +: 32] = addr_of(0);

        // Contention after reset: 0,1,2,0,1,2 with one IDLE between.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        master_enable = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("cont_addr", slave_address, addr_of(k % 3));
            slave_ready  = 1'b1;
            slave_data_i = 32'hD0 + 32'(k);
            settle();
            check("cont_ready", master_ready, 32'(1 << (k % 3)));
            check("cont_rdata", master_data_o, 32'hD0 + 32'(k));
            tick();
            slave_ready = 1'b0;
            settle();
            check("cont_idle_gap", slave_enable, 0);
        end
        master_enable = 3'b000;
        slave_data_i  = '0;
        tick();

        // Slave error on master 1 (last_grant = 2).
        master_enable = 3'b010;
        tick();
        slave_error = 1'b1;
        settle();
        check("err_error", master_error, 3'b010);
        check("err_ready", master_ready, 0);
        tick();
        slave_error   = 1'b0;
        master_enable = 3'b000;
        settle();
        check("err_cleared", master_error, 0);

        // Two requesters, last_grant = 1: master 0 first, then master 1.
        master_enable = 3'b011;
        tick();
        check("rr_first_addr", slave_address, addr_of(0));
        slave_ready = 1'b1;
        settle();
        check("rr_first_ready", master_ready, 3'b001);
        check("rr_loser_error", master_error, 0);
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b010;
        tick();
        check("rr_second_addr", slave_address, addr_of(1));
        slave_ready = 1'b1;
        settle();
        check("rr_second_ready", master_ready, 3'b010);
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b000;
        tick();

        // Abort by master 2, then last_grant = 2 makes master 0 win.
        master_enable = 3'b100;
        tick();
        check("abort_busy_en", slave_enable, 1);
        master_enable = 3'b000;
        settle();
        check("abort_en_drop", slave_enable, 0);
        check("abort_ready", master_ready, 0);
        check("abort_error", master_error, 0);
        tick();
        check("abort_idle", slave_enable, 0);
        master_enable = 3'b011;
        tick();
        check("abort_next_addr", slave_address, addr_of(0));
        slave_ready = 1'b1;
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b000;
        tick();

        // Reset mid-BUSY (master 1 granted) -> master 0 wins afterwards.
        master_enable = 3'b111;
        tick();
        check("rstbusy_addr", slave_address, addr_of(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rstbusy_en", slave_enable, 0);
        check("rstbusy_ready", master_ready, 0);
        check("rstbusy_error", master_error, 0);
        check("rstbusy_saddr", slave_address, 0);
        tick();
        check("rstbusy_winner", slave_address, addr_of(0));
        slave_ready = 1'b1;
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b000;
        tick();

`ifdef BUS_TIMEOUT_EN
        // Watchdog fires on the 5th BUSY cycle (counter = TO).
        master_enable = 3'b001;
        tick();
        for (int c = 0; c < TO; c++) begin
            check("to_pre_error", master_error, 0);
            check("to_pre_en", slave_enable, 1);
            tick();
        end
        check("to_error", master_error, 3'b001);
        check("to_en_forced", slave_enable, 0);
        tick();
        check("to_idle_en", slave_enable, 0);
        check("to_idle_error", master_error, 0);
        master_enable = 3'b000;
        tick();
        // Ready arriving in the deadline cycle wins over the watchdog.
        master_enable = 3'b001;
        tick();
        for (int c = 0; c < TO; c++) tick();
        slave_ready = 1'b1;
        settle();
        check("to_tie_ready", master_ready, 3'b001);
        check("to_tie_error", master_error, 0);
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b000;
        tick();
`else
        // Without the watchdog a stalled slave keeps the bus BUSY indefinitely.
        master_enable = 3'b001;
        tick();
        for (int c = 0; c < 100; c++) begin
            check("nto_busy_en", slave_enable, 1);
            check("nto_no_error", master_error, 0);
            tick();
        end
        slave_ready = 1'b1;
        settle();
        check("nto_final_ready", master_ready, 3'b001);
        tick();
        slave_ready   = 1'b0;
        master_enable = 3'b000;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter NMASTERS, default 3, number of bus masters (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum BUSY cycles before the bus error fires (1..65535).
REQ-003 clk  input  1  bus clock; one clock domain; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 master_address  input  32*NMASTERS  per-master address; master i at bits [32*i +: 32].
REQ-006 master_data_i  input  32*NMASTERS  per-master write data, same packing.
REQ-007 master_wr  input  4*NMASTERS  per-master byte write strobes; all zero means read.
REQ-008 master_enable  input  NMASTERS  per-master request; held until that master's ready or error.
REQ-009 master_data_o  output  32  read data, shared by all masters.
REQ-010 master_ready  output  NMASTERS  per-master completion, one-hot or zero.
REQ-011 master_error  output  NMASTERS  per-master error, one-hot or zero.
REQ-012 slave_data_i  input  32  read data from the address decoder/mux.
REQ-013 slave_ready  input  1  slave completion.
REQ-014 slave_error  input  1  slave error, for example an unmapped address.
REQ-015 slave_address  output  32  granted master's address.
REQ-016 slave_data_o  output  32  granted master's write data.
REQ-017 slave_wr  output  4  granted master's strobes.
REQ-018 slave_enable  output  1  request to the slave side.

Function
REQ-019 The FSM SHALL have two states, IDLE and BUSY, plus a registered grant index and a last_grant pointer.
REQ-020 In IDLE with any master_enable set, the block SHALL grant the first requester found searching upward from last_grant+1 modulo NMASTERS, load the grant index and enter BUSY on the next edge.
REQ-021 In IDLE, slave_enable SHALL be 0; arbitration latency is exactly one cycle from the first sampled enable to slave_enable=1.
REQ-022 In BUSY, slave_enable SHALL equal master_enable[grant]. slave_address, slave_data_o and slave_wr SHALL combinationally follow the granted master.
REQ-023 In BUSY, master_ready[grant] SHALL equal slave_ready and master_error[grant] SHALL equal slave_error; every other bit SHALL be 0.
REQ-024 master_data_o SHALL equal slave_data_i.
REQ-025 When slave_ready or slave_error is sampled in BUSY, the block SHALL set last_grant to grant and return to IDLE.
REQ-026 Back-to-back transfers therefore SHALL have one IDLE cycle between them, which lets the arbiter re-arbitrate fairly.
REQ-027 If master_enable[grant] drops in BUSY without ready or error (abort), the block SHALL return to IDLE with no ready or error pulse and SHALL update last_grant.
REQ-028 If several masters request at once, only one SHALL be granted; losers wait with no ready and no error.
REQ-029 The grant SHALL NOT change while in BUSY.
REQ-030 A new request from a master arriving during another master's BUSY SHALL be served by round-robin order after that transfer ends.
REQ-031 Write strobes SHALL pass through unmodified; the block performs no width conversion.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, grant=0, last_grant=NMASTERS-1 (so master 0 wins first), timeout counter=0.
REQ-033 While in IDLE after reset, slave_enable=0, master_ready=0 and master_error=0.
REQ-034 Reset asserted in BUSY SHALL abort the transfer at that edge, with no ready or error pulse to any master.

Configuration
REQ-035 Macro BUS_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT_CYCLES+1) SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-036 With BUS_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES with no slave_ready or slave_error, the block SHALL force master_error[grant]=1 and slave_enable=0 for that one cycle, then return to IDLE.
REQ-037 If slave_ready and the timeout coincide in the same cycle, slave_ready SHALL win and no error is raised.
REQ-038 Macro BUS_TIMEOUT_EN undefined: no counter SHALL exist, and BUSY SHALL last until slave_ready, slave_error or abort.

Structure
REQ-039 The shared package musb_bus_pkg SHALL hold the state encoding (IDLE/BUSY), the bus width constants (32 address/data bits, 4 strobe bits) and the clog2 function.
REQ-040 One combinational sub-module, rr_priority_picker, SHALL take (request vector, last_grant) and return (valid, index).
REQ-041 All state, the counter and the grant register SHALL stay in bus_arbiter_rr.

Verification
REQ-042 Single master: rst released, master_enable=3'b001, addr=0x100, slave_ready on the 3rd BUSY cycle -> slave_enable rises 1 cycle after the request, master_ready=3'b001 for 1 cycle, slave_address=0x100.
REQ-043 Contention: masters 0, 1 and 2 request continuously, each slave reply takes 1 cycle -> grant order 0,1,2,0,1,2, with exactly one IDLE cycle between transfers.
REQ-044 Error: master 1 request, slave_error=1 -> master_error=3'b010 for 1 cycle, master_ready=0.
REQ-045 Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never ready -> master_error[grant] pulses 4 cycles after BUSY entry, then the FSM returns to IDLE; an identical build without the macro stays in BUSY for 100 cycles.
REQ-046 Abort and reset: master 2 drops enable in BUSY -> return to IDLE with no pulses. rst asserted mid-BUSY -> all outputs 0 next cycle and master 0 wins the next contention.
